product_accumulator: RTL and testbench

//  Downstream consumer of array_multiplier. Sums ACC_LEN consecutive valid products
//  (Z_final / o_valid) into one dot-product result. The result is presented through a
//  one-entry output slot with a valid/ready handshake.
//  The multiplier cannot stall, so this block never back-pressures its input. A result

---
 rtl/product_accumulator.sv | 101 ++++++++++
 tb/tb_product_accumulator.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/product_accumulator.sv
// Sums ACC_LEN consecutive valid products into one result, presented through a
// one-entry valid/ready output slot. The input is never back-pressured.
module product_accumulator #(
  parameter int DATAWIDTH   = 4,
  parameter int ACC_LEN     = 4,
  parameter int INSTANCE_ID = 0,
  localparam int ACCWIDTH   = 2*DATAWIDTH + $clog2(ACC_LEN),
  localparam int CNTWIDTH   = $clog2(ACC_LEN+1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_valid,
  input  logic [2*DATAWIDTH-1:0] i_product,
  input  logic                   i_clear,
  input  logic                   i_ready,
  output logic [ACCWIDTH-1:0]    o_sum,
  output logic                   o_valid,
  output logic [CNTWIDTH-1:0]    o_count,
  output logic                   o_overrun
);

  typedef enum logic {EMPTY, FULL} slot_e;

  slot_e               state_q, state_d;
  logic [ACCWIDTH-1:0] acc_q, acc_d;
  logic [ACCWIDTH-1:0] sum_q, sum_d;
  logic [CNTWIDTH-1:0] cnt_q, cnt_d;
  logic                ovr_q, ovr_d;

  logic [ACCWIDTH-1:0] result;
  logic                last, complete;

  assign result   = acc_q + ACCWIDTH'(i_product);
  assign last     = (cnt_q == CNTWIDTH'(ACC_LEN-1));
  assign complete = i_valid & ~i_clear & last;

  // Accumulator / product counter; clear wins over a same-cycle product.
  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (i_clear) begin
      acc_d = '0;
      cnt_d = '0;
    end else if (i_valid) begin
      if (last) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d = result;
        cnt_d = cnt_q + CNTWIDTH'(1);
      end
    end
  end

  // Output slot: a completion while FULL either replaces (if drained this
  // cycle) or is dropped and flagged.
  always_comb begin
    state_d = state_q;
    sum_d   = sum_q;
    ovr_d   = ovr_q;
    case (state_q)
      EMPTY: begin
        if (complete) begin
          state_d = FULL;
          sum_d   = result;
        end
      end
      FULL: begin
        if (i_ready) begin
          if (complete) sum_d   = result;
          else          state_d = EMPTY;
        end else if (complete) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      acc_q   <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign o_sum     = sum_q;
  assign o_valid   = (state_q == FULL);
  assign o_count   = cnt_q;
  assign o_overrun = ovr_q;

endmodule

// File: tb/tb_product_accumulator.sv
// Randomized and directed checks of product_accumulator against a
// cycle-level arithmetic model; a second ACC_LEN=1 instance checks pass-through.
module tb_product_accumulator;
  localparam int DW   = 4;
  localparam int AL   = 4;
  localparam int ACCW = 2*DW + $clog2(AL);
  localparam int CW   = $clog2(AL+1);

  logic            clk = 1'b0;
  logic            rst, i_valid, i_clear, i_ready;
  logic [2*DW-1:0] i_product;
  logic [ACCW-1:0] o_sum;
  logic            o_valid, o_overrun;
  logic [CW-1:0]   o_count;
  logic [2*DW-1:0] o_sum1;
  logic            o_valid1, o_overrun1;
  logic [0:0]      o_count1;

  int n_chk = 0, n_fail = 0;
  int m_acc, m_cnt, m_sum;
  bit m_full, m_ovr;

  product_accumulator #(.DATAWIDTH(DW), .ACC_LEN(AL), .INSTANCE_ID(0)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product),
    .i_clear(i_clear), .i_ready(i_ready), .o_sum(o_sum), .o_valid(o_valid),
    .o_count(o_count), .o_overrun(o_overrun));

  product_accumulator #(.DATAWIDTH(DW), .ACC_LEN(1), .INSTANCE_ID(1)) dut1 (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_product(i_product),
    .i_clear(i_clear), .i_ready(i_ready), .o_sum(o_sum1), .o_valid(o_valid1),
    .o_count(o_count1), .o_overrun(o_overrun1));

  always #5 clk = ~clk;

  // Advance one clock; the model consumes the inputs present at the edge.
  task automatic tick();
    int  res;
    bit  done;
    @(posedge clk);
    done = 0;
    res  = 0;
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_sum = 0; m_full = 0; m_ovr = 0;
    end else begin
      if (i_clear) begin
        m_acc = 0; m_cnt = 0;
      end else if (i_valid) begin
        m_acc += int'(i_product);
        m_cnt++;
        if (m_cnt == AL) begin
          done = 1; res = m_acc; m_acc = 0; m_cnt = 0;
        end
      end
      if (m_full && i_ready) m_full = 0;
      if (done) begin
        if (!m_full) begin m_full = 1; m_sum = res; end
        else m_ovr = 1;
      end
    end
    #1;
  endtask

  task automatic drive(bit v, int p, bit c, bit r);
    i_valid = v; i_product = (2*DW)'(p); i_clear = c; i_ready = r;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++)
      drive(1'($urandom), $urandom_range(0, 255), 1'($urandom), 1'($urandom));
    rst = 1'b0;
    n_chk++;
    if ({o_sum, o_valid, o_count, o_overrun} !== '0) begin
      n_fail++;
      $display("FAIL reset: sum=%0d valid=%0b count=%0d ovr=%0b, want all 0",
               o_sum, o_valid, o_count, o_overrun);
    end
  endtask

  task automatic test_back_to_back();
    int prods[4] = '{225, 135, 150, 225};
    int cnts[4]  = '{1, 2, 3, 0};
    do_reset();
    n_chk++;
    if (o_count !== 0) begin n_fail++; $display("FAIL b2b_count0: got %0d want 0", o_count); end
    for (int i = 0; i < 4; i++) begin
      drive(1, prods[i], 0, 1);
      n_chk++;
      if (o_count !== CW'(cnts[i])) begin
        n_fail++; $display("FAIL b2b_count[%0d]: got %0d want %0d", i, o_count, cnts[i]);
      end
    end
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(735)) begin
      n_fail++; $display("FAIL b2b_sum: valid=%0b sum=%0d want 1/735", o_valid, o_sum);
    end
    drive(0, 0, 0, 1);
    n_chk++;
    if (o_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_pulse: valid=%0b want 0", o_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(4) || o_overrun !== 1'b0) begin
      n_fail++; $display("FAIL bp_first: valid=%0b sum=%0d ovr=%0b want 1/4/0", o_valid, o_sum, o_overrun);
    end
    for (int i = 0; i < 4; i++) drive(1, 2, 0, 0);
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(4) || o_overrun !== 1'b1) begin
      n_fail++; $display("FAIL bp_overrun: valid=%0b sum=%0d ovr=%0b want 1/4/1", o_valid, o_sum, o_overrun);
    end
    drive(0, 0, 0, 1);
    n_chk++;
    if (o_valid !== 1'b0 || o_sum !== ACCW'(4) || o_overrun !== 1'b1) begin
      n_fail++; $display("FAIL bp_drain: valid=%0b sum=%0d ovr=%0b want 0/4/1", o_valid, o_sum, o_overrun);
    end
  endtask

  task automatic test_accept_and_complete();
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) drive(1, 3, 0, 0);
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(4)) begin
      n_fail++; $display("FAIL ac_hold: valid=%0b sum=%0d want 1/4", o_valid, o_sum);
    end
    drive(1, 3, 0, 1);
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(12) || o_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ac_swap: valid=%0b sum=%0d ovr=%0b want 1/12/0", o_valid, o_sum, o_overrun);
    end
  endtask

  task automatic test_clear();
    do_reset();
    drive(1, 10, 0, 1);
    drive(1, 20, 0, 1);
    drive(0, 0, 1, 1);
    n_chk++;
    if (o_count !== 0) begin n_fail++; $display("FAIL clr_count: got %0d want 0", o_count); end
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1);
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(4)) begin
      n_fail++; $display("FAIL clr_sum: valid=%0b sum=%0d want 1/4", o_valid, o_sum);
    end
    drive(1, 9, 1, 1);
    n_chk++;
    if (o_count !== 0 || o_valid !== 1'b0) begin
      n_fail++; $display("FAIL clr_win: count=%0d valid=%0b want 0/0", o_count, o_valid);
    end
    for (int i = 0; i < 4; i++) drive(1, 2, 0, 1);
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(8)) begin
      n_fail++; $display("FAIL clr_after: valid=%0b sum=%0d want 1/8", o_valid, o_sum);
    end
  endtask

  task automatic test_gaps_and_reset();
    int prods[4] = '{225, 135, 150, 225};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      int gap = $urandom_range(0, 3);
      for (int g = 0; g < gap; g++) drive(0, $urandom_range(0, 255), 0, 1);
      drive(1, prods[i], 0, 1);
    end
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(735)) begin
      n_fail++; $display("FAIL gap_sum: valid=%0b sum=%0d want 1/735", o_valid, o_sum);
    end
    drive(1, 50, 0, 1);
    drive(1, 60, 0, 1);
    do_reset();
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1);
    n_chk++;
    if (o_valid !== 1'b1 || o_sum !== ACCW'(4)) begin
      n_fail++; $display("FAIL rst_mid: valid=%0b sum=%0d want 1/4", o_valid, o_sum);
    end
  endtask

  task automatic test_acc_len1();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      bit v = 1'($urandom);
      int p = $urandom_range(0, 255);
      drive(v, p, 0, 1);
      n_chk++;
      if (o_valid1 !== v || (v && o_sum1 !== (2*DW)'(p))) begin
        n_fail++; $display("FAIL len1[%0d]: valid=%0b sum=%0d want %0b/%0d", i, o_valid1, o_sum1, v, p);
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 59) == 0);
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 255),
            $urandom_range(0, 11) == 0, 1'($urandom));
      n_chk++;
      if ({o_sum, o_valid, o_count, o_overrun} !==
          {ACCW'(m_sum), m_full, CW'(m_cnt), m_ovr}) begin
        n_fail++;
        $display("FAIL rand[%0d]: sum=%0d valid=%0b count=%0d ovr=%0b want %0d/%0b/%0d/%0b",
                 i, o_sum, o_valid, o_count, o_overrun, m_sum, m_full, m_cnt, m_ovr);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b0; i_valid = 1'b0; i_product = '0; i_clear = 1'b0; i_ready = 1'b0;
    m_acc = 0; m_cnt = 0; m_sum = 0; m_full = 0; m_ovr = 0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_accept_and_complete();
    test_clear();
    test_gaps_and_reset();
    test_acc_len1();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
